mem_loader: RTL

- Byte-stream program loader that drives the CPU top's external memory write port: Ext_MemWrite, Ext_WriteData and Ext_DataAdr.
- Holds the CPU in reset (cpu_hold) while it assembles little-endian words from a byte stream (typically a UART receiver) and writes them to consecutive word addresses.
- Releases the CPU when the frame completes.
- Sits beside the CPU top; cpu_hold is ORed into the CPU's reset input at the system level.

---
 rtl/mem_loader_if.sv | 27 ++
 rtl/mem_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader_if.sv
// Loader bus: byte-stream input side plus the CPU external memory write port and status.
interface mem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;
  logic        cpu_hold;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic [31:0] words_loaded;
  logic        load_done;
  logic        load_error;

  // Loader side: consumes bytes and reload, drives the memory port and status.
  modport master (
    input  rx_data, rx_valid, reload,
    output cpu_hold, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           words_loaded, load_done, load_error
  );

  // System side: supplies bytes and reload, observes the memory port and status.
  modport slave (
    output rx_data, rx_valid, reload,
    input  cpu_hold, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           words_loaded, load_done, load_error
  );
endinterface

// File: rtl/mem_loader.sv
// Byte-stream program loader: holds the CPU in reset while it assembles
// little-endian words from a byte stream and writes them to consecutive
// word addresses, then releases the CPU when the frame completes.
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned TIMEOUT   = 1_000_000,
  parameter int unsigned TO_W      = 20
) (
  input logic         clk,
  input logic         reset,
  mem_loader_if.master bus
);

  typedef enum logic [1:0] {
    ST_LEN   = 2'd0,
    ST_DATA  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } loaderState_t;

  loaderState_t    state, stateNxt;
  logic [1:0]      byteIdx, byteIdxNxt;
  logic [31:0]     lenWord, lenWordNxt;
  logic [23:0]     asmWord, asmWordNxt;
  logic [TO_W-1:0] toCnt, toCntNxt;

  logic            cpuHold, cpuHoldNxt;
  logic            memWrite, memWriteNxt;
  logic [31:0]     writeData, writeDataNxt;
  logic [31:0]     dataAdr, dataAdrNxt;
  logic [31:0]     wordsLoaded, wordsLoadedNxt;
  logic            loadDone, loadDoneNxt;
  logic            loadError, loadErrorNxt;

  logic [31:0]     lenFull;
  logic [31:0]     wordsNext;
  logic            byteLast;
  logic            lastWord;
  logic            timedOut;
  logic            toActive;

  // Count value as it stands once the byte arriving now is included.
  assign lenFull   = {bus.rx_data, lenWord[23:0]};
  assign wordsNext = wordsLoaded + 32'd1;
  assign byteLast  = (byteIdx == 2'd3);
  assign lastWord  = (wordsNext == lenWord);
  assign timedOut  = (toCnt >= TO_W'(TIMEOUT));
  // Idle timer only runs once a frame has started.
  assign toActive  = (state == ST_DATA) || (state == ST_WRITE) ||
                     ((state == ST_LEN) && (byteIdx != 2'd0));

  // State and datapath registers; every output is taken straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_LEN;
      byteIdx     <= 2'd0;
      lenWord     <= 32'd0;
      asmWord     <= 24'd0;
      toCnt       <= '0;
      cpuHold     <= 1'b1;
      memWrite    <= 1'b0;
      writeData   <= 32'd0;
      dataAdr     <= BASE_ADDR;
      wordsLoaded <= 32'd0;
      loadDone    <= 1'b0;
      loadError   <= 1'b0;
    end else begin
      state       <= stateNxt;
      byteIdx     <= byteIdxNxt;
      lenWord     <= lenWordNxt;
      asmWord     <= asmWordNxt;
      toCnt       <= toCntNxt;
      cpuHold     <= cpuHoldNxt;
      memWrite    <= memWriteNxt;
      writeData   <= writeDataNxt;
      dataAdr     <= dataAdrNxt;
      wordsLoaded <= wordsLoadedNxt;
      loadDone    <= loadDoneNxt;
      loadError   <= loadErrorNxt;
    end
  end

  // Next-state decode: frame parsing, write sequencing, timeout abort and reload.
  always_comb begin
    stateNxt = state;
    case (state)
      ST_LEN: begin
        if (timedOut && (byteIdx != 2'd0)) begin
          stateNxt = ST_LEN;
        end else if (bus.rx_valid && byteLast) begin
          if (lenFull == 32'd0) begin
            stateNxt = ST_RUN;
          end else if (lenFull > 32'(MAX_WORDS)) begin
            stateNxt = ST_LEN;
          end else begin
            stateNxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (timedOut) begin
          stateNxt = ST_LEN;
        end else if (bus.rx_valid && byteLast) begin
          stateNxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        stateNxt = lastWord ? ST_RUN : ST_DATA;
      end
      ST_RUN: begin
        if (bus.reload) begin
          stateNxt = ST_LEN;
        end
      end
      default: stateNxt = ST_LEN;
    endcase
  end

  // Next values for datapath and outputs, derived from the current and next state.
  always_comb begin
    byteIdxNxt     = byteIdx;
    lenWordNxt     = lenWord;
    asmWordNxt     = asmWord;
    writeDataNxt   = writeData;
    dataAdrNxt     = dataAdr;
    wordsLoadedNxt = wordsLoaded;
    loadErrorNxt   = loadError;
    memWriteNxt    = 1'b0;
    toCntNxt       = toCnt;

    // Idle timer: cleared by any byte or outside a frame; held once expired in WRITE.
    if (!toActive || bus.rx_valid || (stateNxt == ST_RUN)) begin
      toCntNxt = '0;
    end else if (timedOut) begin
      toCntNxt = (state == ST_WRITE) ? toCnt : '0;
    end else begin
      toCntNxt = toCnt + TO_W'(1);
    end

    case (state)
      ST_LEN: begin
        if (timedOut && (byteIdx != 2'd0)) begin
          byteIdxNxt   = 2'd0;
          loadErrorNxt = 1'b1;
        end else if (bus.rx_valid) begin
          lenWordNxt[{byteIdx, 3'b000} +: 8] = bus.rx_data;
          byteIdxNxt = byteIdx + 2'd1;
          if (byteLast) begin
            if (lenFull > 32'(MAX_WORDS)) begin
              loadErrorNxt = 1'b1;
            end else begin
              wordsLoadedNxt = 32'd0;
            end
          end
        end
      end
      ST_DATA: begin
        if (timedOut) begin
          byteIdxNxt   = 2'd0;
          loadErrorNxt = 1'b1;
        end else if (bus.rx_valid) begin
          byteIdxNxt = byteIdx + 2'd1;
          case (byteIdx)
            2'd0: asmWordNxt[7:0]   = bus.rx_data;
            2'd1: asmWordNxt[15:8]  = bus.rx_data;
            2'd2: asmWordNxt[23:16] = bus.rx_data;
            default: begin
              memWriteNxt  = 1'b1;
              writeDataNxt = {bus.rx_data, asmWord};
              dataAdrNxt   = BASE_ADDR + {wordsLoaded[29:0], 2'b00};
            end
          endcase
        end
      end
      ST_WRITE: begin
        wordsLoadedNxt = wordsNext;
        // A byte landing during a non-final write starts the next word.
        if (!lastWord && bus.rx_valid) begin
          asmWordNxt[7:0] = bus.rx_data;
          byteIdxNxt      = 2'd1;
        end
      end
      ST_RUN: begin
        if (bus.reload) begin
          byteIdxNxt     = 2'd0;
          wordsLoadedNxt = 32'd0;
        end
      end
      default: ;
    endcase

    // A completed frame clears any earlier error.
    if ((stateNxt == ST_RUN) && (state != ST_RUN)) begin
      loadErrorNxt = 1'b0;
    end
  end

  logic cpuHoldNxtC;
  logic loadDoneNxtC;
  assign cpuHoldNxtC  = (stateNxt != ST_RUN);
  assign loadDoneNxtC = (stateNxt == ST_RUN);

  // Status flags track the state the FSM is entering.
  always_comb begin
    cpuHoldNxt  = cpuHoldNxtC;
    loadDoneNxt = loadDoneNxtC;
  end

  assign bus.cpu_hold      = cpuHold;
  assign bus.Ext_MemWrite  = memWrite;
  assign bus.Ext_WriteData = writeData;
  assign bus.Ext_DataAdr   = dataAdr;
  assign bus.words_loaded  = wordsLoaded;
  assign bus.load_done     = loadDone;
  assign bus.load_error    = loadError;

endmodule
